// File: rtl/count_window_sequencer.sv
// Gated photon-counting sequencer: counts pulse_in rising edges over a number of fixed-length windows
// and hands each window's count to a consumer. Optional trigger output enabled by `define TRIGGER_OUT_EN.
module count_window_sequencer #(
  parameter int COUNT_WIDTH = 32,
  parameter int IDX_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [IDX_WIDTH-1:0]   num_windows,
  input  logic [COUNT_WIDTH-1:0] gate_cycles,
  input  logic [COUNT_WIDTH-1:0] ncounts,
  input  logic                   pulse_in,
  output logic [COUNT_WIDTH-1:0] count_data,
  output logic                   count_valid,
  input  logic                   count_ready,
  output logic [IDX_WIDTH-1:0]   window_idx,
  output logic                   busy,
  output logic                   done,
  output logic                   dead_edge
`ifdef TRIGGER_OUT_EN
  ,
  output logic                   trigger
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] COUNT  = 2'd1;
  localparam logic [1:0] REPORT = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};
  localparam logic [IDX_WIDTH-1:0]   IDX_ONE = {{(IDX_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]             state;
  logic                   prev;
  logic [IDX_WIDTH-1:0]   cfg_windows;
  logic [COUNT_WIDTH-1:0] cfg_gate;
  logic [COUNT_WIDTH-1:0] count;
  logic [COUNT_WIDTH-1:0] gate_timer;

  logic                   pulse_edge;
  logic                   start_run;
  logic                   last_window;
  logic [COUNT_WIDTH-1:0] gate_last;
  logic [COUNT_WIDTH-1:0] count_next;

  assign pulse_edge  = pulse_in & ~prev;
  assign start_run   = (state == IDLE) && !abort && start && (num_windows != '0);
  // A zero gate length behaves as a one-clock window.
  assign gate_last   = (cfg_gate == '0) ? '0 : cfg_gate - CNT_ONE;
  assign count_next  = (count == CNT_MAX) ? count : count + CNT_ONE;
  assign last_window = ({1'b0, window_idx} + {{IDX_WIDTH{1'b0}}, 1'b1}) >= {1'b0, cfg_windows};

  assign count_data  = count;
  assign count_valid = (state == REPORT);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      prev        <= 1'b0;
      cfg_windows <= '0;
      cfg_gate    <= '0;
      count       <= '0;
      gate_timer  <= '0;
      window_idx  <= '0;
      dead_edge   <= 1'b0;
    end else begin
      prev <= pulse_in;
      if (pulse_edge && (state == REPORT || state == DONE))
        dead_edge <= 1'b1;
      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start_run) begin
              cfg_windows <= num_windows;
              cfg_gate    <= gate_cycles;
              count       <= '0;
              gate_timer  <= '0;
              window_idx  <= '0;
              dead_edge   <= 1'b0;
              state       <= COUNT;
            end
          end
          COUNT: begin
            if (pulse_edge)
              count <= count_next;
            if (gate_timer == gate_last) begin
              gate_timer <= '0;
              state      <= REPORT;
            end else begin
              gate_timer <= gate_timer + CNT_ONE;
            end
          end
          REPORT: begin
            if (count_ready) begin
              if (last_window) begin
                state <= DONE;
              end else begin
                window_idx <= window_idx + IDX_ONE;
                count      <= '0;
                state      <= COUNT;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef TRIGGER_OUT_EN
  logic [COUNT_WIDTH-1:0] cfg_ncounts;
  logic                   trig_fired;

  // trig_fired re-arms whenever the sequencer leaves COUNT, so each window fires at most once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_ncounts <= '0;
      trig_fired  <= 1'b0;
      trigger     <= 1'b0;
    end else begin
      trigger <= 1'b0;
      if (start_run)
        cfg_ncounts <= ncounts;
      if (state != COUNT) begin
        trig_fired <= 1'b0;
      end else if (!abort && pulse_edge && !trig_fired &&
                   (cfg_ncounts != '0) && (count_next == cfg_ncounts)) begin
        trigger    <= 1'b1;
        trig_fired <= 1'b1;
      end
    end
  end
`else
  logic unused_ncounts;
  assign unused_ncounts = ^ncounts;
`endif

endmodule

// File: tb/tb_count_window_sequencer.sv
// Randomized and directed bench for count_window_sequencer; the expected counts come from a
// behavioural edge-counting model. Trigger checks are active when TRIGGER_OUT_EN is defined.
module tb_count_window_sequencer;
  localparam int CW = 16;
  localparam int IW = 8;

  logic          clk, rst, start, abort, pulse_in, count_ready;
  logic [IW-1:0] num_windows;
  logic [CW-1:0] gate_cycles, ncounts;
  logic [CW-1:0] count_data;
  logic          count_valid, busy, done, dead_edge;
  logic [IW-1:0] window_idx;
`ifdef TRIGGER_OUT_EN
  logic          trigger;
`endif

  int   n_checks = 0;
  int   n_pass = 0;
  int   done_seen = 0;
  int   trig_seen = 0;
  int   trig_tick = -1;
  int   tick_no = 0;
  logic model_prev = 1'b0;

  count_window_sequencer #(.COUNT_WIDTH(CW), .IDX_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .num_windows(num_windows), .gate_cycles(gate_cycles), .ncounts(ncounts),
    .pulse_in(pulse_in), .count_data(count_data), .count_valid(count_valid),
    .count_ready(count_ready), .window_idx(window_idx), .busy(busy), .done(done),
    .dead_edge(dead_edge)
`ifdef TRIGGER_OUT_EN
    , .trigger(trigger)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // One clock: the model derives the rising edge the DUT sees at this posedge from the driven level.
  task automatic tick(output bit e);
    e = pulse_in & ~model_prev;
    model_prev = pulse_in;
    @(posedge clk);
    #1;
    tick_no++;
    if (done === 1'b1) done_seen++;
`ifdef TRIGGER_OUT_EN
    if (trigger === 1'b1) begin
      trig_seen++;
      if (trig_tick < 0) trig_tick = tick_no;
    end
`endif
  endtask

  task automatic do_start(input int w, input int g, input int nc);
    bit e;
    num_windows = IW'(w);
    gate_cycles = CW'(g);
    ncounts     = CW'(nc);
    start = 1'b1;
    tick(e);
    start = 1'b0;
    num_windows = IW'($urandom);
    gate_cycles = CW'($urandom);
    ncounts     = CW'($urandom);
  endtask

  task automatic test_reset();
    bit e;
    rst = 1'b0; start = 1'b0; abort = 1'b0; pulse_in = 1'b0; count_ready = 1'b0;
    num_windows = '0; gate_cycles = '0; ncounts = '0; model_prev = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (count_data !== '0) $display("[TB] FAIL reset_count_data: got %0d expected 0", count_data); else n_pass++;
    n_checks++; if ({count_valid, busy, done, dead_edge} !== 4'b0) $display("[TB] FAIL reset_flags: got %b expected 0000", {count_valid, busy, done, dead_edge}); else n_pass++;
    n_checks++; if (window_idx !== '0) $display("[TB] FAIL reset_window_idx: got %0d expected 0", window_idx); else n_pass++;
`ifdef TRIGGER_OUT_EN
    n_checks++; if (trigger !== 1'b0) $display("[TB] FAIL reset_trigger: got %b expected 0", trigger); else n_pass++;
`endif
    rst = 1'b1;
    tick(e);
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_release_busy: got %b expected 0", busy); else n_pass++;
  endtask

  task automatic test_basic();
    bit e;
    done_seen = 0;
    count_ready = 1'b1;
    do_start(2, 10, 0);
    for (int w = 0; w < 2; w++) begin
      for (int c = 0; c < 10; c++) begin
        pulse_in = (c == 1 || c == 4 || c == 7);
        tick(e);
      end
      n_checks++; if (count_valid !== 1'b1) $display("[TB] FAIL basic_valid_w%0d: got %b expected 1", w, count_valid); else n_pass++;
      n_checks++; if (count_data !== CW'(3)) $display("[TB] FAIL basic_data_w%0d: got %0d expected 3", w, count_data); else n_pass++;
      n_checks++; if (window_idx !== IW'(w)) $display("[TB] FAIL basic_idx_w%0d: got %0d expected %0d", w, window_idx, w); else n_pass++;
      pulse_in = 1'b0;
      tick(e);
    end
    n_checks++; if (done !== 1'b1) $display("[TB] FAIL basic_done_pulse: got %b expected 1", done); else n_pass++;
    tick(e);
    n_checks++; if ({done, busy} !== 2'b00) $display("[TB] FAIL basic_idle: got done,busy=%b expected 00", {done, busy}); else n_pass++;
    n_checks++; if (window_idx !== IW'(1)) $display("[TB] FAIL basic_idx_hold: got %0d expected 1", window_idx); else n_pass++;
    n_checks++; if (done_seen != 1) $display("[TB] FAIL basic_done_count: got %0d expected 1", done_seen); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit e;
    logic [CW-1:0] cnt;
    count_ready = 1'b0;
    cnt = '0;
    do_start(1, 4, 0);
    for (int c = 0; c < 4; c++) begin
      pulse_in = (c % 2 == 0);
      tick(e);
      if (e) cnt++;
    end
    n_checks++; if (count_valid !== 1'b1 || count_data !== cnt) $display("[TB] FAIL bp_report: got valid=%b data=%0d expected valid=1 data=%0d", count_valid, count_data, cnt); else n_pass++;
    n_checks++; if (dead_edge !== 1'b0) $display("[TB] FAIL bp_dead_before: got %b expected 0", dead_edge); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      pulse_in = (k == 2);
      tick(e);
      n_checks++; if (count_valid !== 1'b1 || count_data !== cnt) $display("[TB] FAIL bp_hold_%0d: got valid=%b data=%0d expected valid=1 data=%0d", k, count_valid, count_data, cnt); else n_pass++;
    end
    n_checks++; if (dead_edge !== 1'b1) $display("[TB] FAIL bp_dead_set: got %b expected 1", dead_edge); else n_pass++;
    count_ready = 1'b1;
    pulse_in = 1'b0;
    tick(e);
    tick(e);
    n_checks++; if (dead_edge !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL bp_dead_sticky: got dead=%b busy=%b expected dead=1 busy=0", dead_edge, busy); else n_pass++;
    do_start(1, 1, 0);
    n_checks++; if (dead_edge !== 1'b0) $display("[TB] FAIL bp_dead_clear_on_start: got %b expected 0", dead_edge); else n_pass++;
    repeat (3) tick(e);
  endtask

  task automatic test_gate_boundary();
    bit e;
    logic [CW-1:0] cnt;
    logic pw [3];
    logic ph [3];
    count_ready = 1'b1;
    pulse_in = 1'b0;
    do_start(2, 3, 0);
    cnt = '0;
    for (int c = 0; c < 3; c++) begin
      pulse_in = (c == 2);
      tick(e);
      if (e) cnt++;
    end
    n_checks++; if (count_data !== cnt || cnt !== CW'(1)) $display("[TB] FAIL gb_w0: got %0d expected 1", count_data); else n_pass++;
    tick(e);
    cnt = '0;
    for (int c = 0; c < 3; c++) begin
      tick(e);
      if (e) cnt++;
    end
    n_checks++; if (count_data !== cnt || window_idx !== IW'(1)) $display("[TB] FAIL gb_w1_held_high: got data=%0d idx=%0d expected data=%0d idx=1", count_data, window_idx, cnt); else n_pass++;
    pulse_in = 1'b0;
    tick(e);
    tick(e);
    n_checks++; if (dead_edge !== 1'b0) $display("[TB] FAIL gb_no_dead: got %b expected 0", dead_edge); else n_pass++;
    pw = '{1'b1, 1'b1, 1'b1};
    ph = '{1'b0, 1'b1, 1'b1};
    do_start(3, 0, 0);
    for (int w = 0; w < 3; w++) begin
      pulse_in = pw[w];
      tick(e);
      cnt = e ? CW'(1) : CW'(0);
      n_checks++; if (count_valid !== 1'b1 || count_data !== cnt) $display("[TB] FAIL gb_zero_gate_w%0d: got valid=%b data=%0d expected valid=1 data=%0d", w, count_valid, count_data, cnt); else n_pass++;
      pulse_in = ph[w];
      tick(e);
    end
    pulse_in = 1'b0;
    tick(e);
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL gb_zero_gate_end: got busy=%b expected 0", busy); else n_pass++;
  endtask

  task automatic test_abort_reset();
    bit e;
    done_seen = 0;
    count_ready = 1'b1;
    do_start(2, 8, 0);
    for (int c = 0; c < 3; c++) begin
      pulse_in = (c != 1);
      tick(e);
    end
    abort = 1'b1;
    tick(e);
    abort = 1'b0;
    n_checks++; if ({busy, count_valid, done} !== 3'b000) $display("[TB] FAIL abort_idle: got busy,valid,done=%b expected 000", {busy, count_valid, done}); else n_pass++;
    pulse_in = 1'b0;
    tick(e);
    n_checks++; if (busy !== 1'b0 || done_seen != 0) $display("[TB] FAIL abort_no_done: got busy=%b dones=%0d expected busy=0 dones=0", busy, done_seen); else n_pass++;
    num_windows = IW'(1); gate_cycles = CW'(3); start = 1'b1; abort = 1'b1;
    tick(e);
    start = 1'b0; abort = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL abort_over_start: got busy=%b expected 0", busy); else n_pass++;
    do_start(2, 2, 0);
    tick(e); tick(e);
    tick(e);
    count_ready = 1'b0;
    tick(e); tick(e);
    n_checks++; if (count_valid !== 1'b1 || window_idx !== IW'(1)) $display("[TB] FAIL rst_pre_report: got valid=%b idx=%0d expected valid=1 idx=1", count_valid, window_idx); else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_checks++; if ({count_valid, busy, done, dead_edge} !== 4'b0 || count_data !== '0 || window_idx !== '0) $display("[TB] FAIL rst_async_zero: got flags=%b data=%0d idx=%0d expected all 0", {count_valid, busy, done, dead_edge}, count_data, window_idx); else n_pass++;
    @(posedge clk);
    #1;
    n_checks++; if ({count_valid, busy, done, dead_edge} !== 4'b0 || count_data !== '0) $display("[TB] FAIL rst_held_zero: got flags=%b data=%0d expected all 0", {count_valid, busy, done, dead_edge}, count_data); else n_pass++;
    pulse_in = 1'b0;
    model_prev = 1'b0;
    rst = 1'b1;
    tick(e);
    n_checks++; if (busy !== 1'b0 || done_seen != 0) $display("[TB] FAIL rst_release_idle: got busy=%b dones=%0d expected busy=0 dones=0", busy, done_seen); else n_pass++;
  endtask

  task automatic test_zero_windows();
    bit e;
    do_start(0, 5, 0);
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL zero_windows_start: got busy=%b expected 0", busy); else n_pass++;
    tick(e);
    n_checks++; if (busy !== 1'b0 || count_valid !== 1'b0) $display("[TB] FAIL zero_windows_idle: got busy=%b valid=%b expected 0 0", busy, count_valid); else n_pass++;
  endtask

`ifdef TRIGGER_OUT_EN
  task automatic test_trigger();
    bit e;
    int edges;
    int e2_tick;
    int e3_tick;
    logic [CW-1:0] cnt;
    trig_seen = 0; trig_tick = -1;
    edges = 0; e2_tick = 0; e3_tick = 0; cnt = '0;
    count_ready = 1'b1;
    pulse_in = 1'b0;
    do_start(1, 12, 2);
    for (int c = 0; c < 12; c++) begin
      pulse_in = (c == 1 || c == 4 || c == 7 || c == 10);
      tick(e);
      if (e) begin
        cnt++;
        edges++;
        if (edges == 2) e2_tick = tick_no;
        if (edges == 3) e3_tick = tick_no;
      end
    end
    n_checks++; if (count_data !== cnt || cnt !== CW'(4)) $display("[TB] FAIL trig_count: got %0d expected 4", count_data); else n_pass++;
    pulse_in = 1'b0;
    tick(e); tick(e);
    n_checks++; if (trig_seen != 1) $display("[TB] FAIL trig_once: got %0d pulses expected 1", trig_seen); else n_pass++;
    n_checks++; if (trig_tick < e2_tick || trig_tick >= e3_tick) $display("[TB] FAIL trig_timing: got tick %0d expected in [%0d,%0d)", trig_tick, e2_tick, e3_tick); else n_pass++;
    trig_seen = 0;
    do_start(1, 6, 0);
    for (int c = 0; c < 6; c++) begin
      pulse_in = (c % 2 == 0);
      tick(e);
    end
    pulse_in = 1'b0;
    tick(e); tick(e);
    n_checks++; if (trig_seen != 0) $display("[TB] FAIL trig_ncounts_zero: got %0d pulses expected 0", trig_seen); else n_pass++;
  endtask
`endif

  task automatic test_random_runs();
    bit e;
    int w_n, g, g_eff, nc, exp_trig, k;
    logic exp_dead;
    logic [CW-1:0] cnt;
    for (int r = 0; r < 12; r++) begin
      w_n = int'($urandom_range(1, 3));
      g   = int'($urandom_range(0, 6));
      g_eff = (g == 0) ? 1 : g;
      nc  = int'($urandom_range(0, 3));
      done_seen = 0; trig_seen = 0; exp_trig = 0; exp_dead = 1'b0;
      count_ready = 1'($urandom_range(0, 1));
      do_start(w_n, g, nc);
      for (int w = 0; w < w_n; w++) begin
        cnt = '0;
        for (int c = 0; c < g_eff; c++) begin
          pulse_in = 1'($urandom_range(0, 1));
          count_ready = 1'($urandom_range(0, 1));
          tick(e);
          if (e) cnt++;
        end
        if (nc != 0 && int'(cnt) >= nc) exp_trig++;
        n_checks++; if (count_valid !== 1'b1 || count_data !== cnt) $display("[TB] FAIL rand_r%0d_w%0d_data: got valid=%b data=%0d expected valid=1 data=%0d", r, w, count_valid, count_data, cnt); else n_pass++;
        n_checks++; if (window_idx !== IW'(w)) $display("[TB] FAIL rand_r%0d_w%0d_idx: got %0d expected %0d", r, w, window_idx, w); else n_pass++;
        k = int'($urandom_range(0, 3));
        count_ready = 1'b0;
        for (int j = 0; j < k; j++) begin
          pulse_in = 1'($urandom_range(0, 1));
          tick(e);
          exp_dead |= e;
          n_checks++; if (count_valid !== 1'b1 || count_data !== cnt) $display("[TB] FAIL rand_r%0d_w%0d_hold: got valid=%b data=%0d expected valid=1 data=%0d", r, w, count_valid, count_data, cnt); else n_pass++;
        end
        count_ready = 1'b1;
        pulse_in = 1'($urandom_range(0, 1));
        tick(e);
        exp_dead |= e;
      end
      n_checks++; if (done !== 1'b1) $display("[TB] FAIL rand_r%0d_done: got %b expected 1", r, done); else n_pass++;
      pulse_in = 1'($urandom_range(0, 1));
      tick(e);
      exp_dead |= e;
      n_checks++; if (busy !== 1'b0 || done_seen != 1) $display("[TB] FAIL rand_r%0d_end: got busy=%b dones=%0d expected busy=0 dones=1", r, busy, done_seen); else n_pass++;
      n_checks++; if (dead_edge !== exp_dead) $display("[TB] FAIL rand_r%0d_dead: got %b expected %b", r, dead_edge, exp_dead); else n_pass++;
`ifdef TRIGGER_OUT_EN
      n_checks++; if (trig_seen != exp_trig) $display("[TB] FAIL rand_r%0d_trig: got %0d expected %0d", r, trig_seen, exp_trig); else n_pass++;
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gate_boundary();
    test_abort_reset();
    test_zero_windows();
`ifdef TRIGGER_OUT_EN
    test_trigger();
`endif
    test_random_runs();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
